// File: rtl/encoder_8input_seq.sv
//-----------------------------------------------------------------------------
// encoder_8input_seq
//
// Sequential 8-to-3 encoder. It accepts an 8-bit request vector and emits
// one 3-bit code for each set bit, one code per handshake. The last code of
// a batch is flagged with `last`. An all-zero vector produces a one-cycle
// `zero_err` pulse and no codes.
//
// Priority:
//   default          : lowest set index first.
//   ENCODER_RR_EN    : round-robin. The search starts just after the last
//                      served index, wraps 7 -> 0, and carries over between
//                      batches (last_served resets to 7).
//
// Ports:
//   clk         in   single clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   req_valid   in   request vector offered
//   req_ready   out  block can accept a vector (high only in IDLE)
//   req_vec     in   request lines, bit i = line i
//   code_valid  out  `code` holds a valid encoded index
//   code_ready  in   consumer accepts the code
//   code        out  binary index of the served request line
//   last        out  high with the final code of a batch
//   zero_err    out  one-cycle pulse after an all-zero vector is accepted
//-----------------------------------------------------------------------------
module encoder_8input_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_vec,
  output logic       code_valid,
  input  logic       code_ready,
  output logic [2:0] code,
  output logic       last,
  output logic       zero_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t     state;
  logic [7:0] pending;       // request bits not yet served
  logic [7:0] served_mask;   // one-hot mask of the code now on the output
  logic [7:0] pending_next;  // pending once the current code is handshaken
  logic [2:0] sel_idx;       // index chosen by the priority search
  logic       sel_last;      // exactly one pending bit left
  logic       accept;
  logic       handshake;

  // Returns the index of the lowest set bit. Returns 0 for an all-zero
  // input, which never reaches the search because SCAN only runs when
  // pending is non-zero.
  function automatic logic [2:0] lowest_index(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // State is IDLE while rst_n is low, so req_ready also reads 1 during reset.
  // No capture can happen then, because the reset branch wins.
  assign req_ready    = (state == IDLE);
  assign accept       = req_ready && req_valid;
  assign handshake    = code_valid && code_ready;

  assign served_mask  = 8'd1 << code;
  assign pending_next = pending & ~served_mask;

  // x & (x-1) clears the lowest set bit, so a zero result on a non-zero x
  // means exactly one bit is set.
  assign sel_last = (pending != 8'd0) && ((pending & (pending - 8'd1)) == 8'd0);

`ifdef ENCODER_RR_EN
  // Round-robin search. Rotate pending right so that bit (last_served+1)
  // moves to position 0. Find the lowest set bit of the rotated vector and
  // add the rotation back. The 3-bit addition gives the 7 -> 0 wrap for free.
  logic [2:0] last_served;
  logic [2:0] start_idx;
  logic [3:0] left_amt;
  logic [7:0] rotated;

  assign start_idx = last_served + 3'd1;
  assign left_amt  = 4'd8 - {1'b0, start_idx};
  assign rotated   = (pending >> start_idx) | (pending << left_amt);
  assign sel_idx   = start_idx + lowest_index(rotated);

  // last_served tracks every completed handshake and is not cleared between
  // batches, so fairness carries over from one vector to the next.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_served <= 3'd7;
    end else if (handshake) begin
      last_served <= code;
    end
  end
`else
  assign sel_idx = lowest_index(pending);
`endif

  // Main controller. All outputs except req_ready are registered here.
  // NOTE: every sequential assignment is non-blocking. All right-hand sides
  // therefore see pre-edge values, so branches may read `pending` and `code`
  // even where they also update them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pending    <= 8'd0;
      code       <= 3'd0;
      code_valid <= 1'b0;
      last       <= 1'b0;
      zero_err   <= 1'b0;
    end else begin
      // zero_err is a single-cycle pulse unless re-armed below.
      zero_err <= 1'b0;

      case (state)
        IDLE: begin
          if (accept) begin
            pending <= req_vec;
            if (req_vec == 8'd0) begin
              zero_err <= 1'b1;
            end else begin
              state <= SCAN;
            end
          end
        end

        SCAN: begin
          code       <= sel_idx;
          last       <= sel_last;
          code_valid <= 1'b1;
          state      <= OUT;
        end

        OUT: begin
          // code, last and code_valid hold until the consumer takes the code.
          if (code_ready) begin
            pending    <= pending_next;
            code_valid <= 1'b0;
            last       <= 1'b0;
            state      <= (pending_next == 8'd0) ? IDLE : SCAN;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  // A presented code stays stable while the consumer stalls.
  a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (code_valid && !code_ready) |=> (code_valid && $stable(code) && $stable(last)));

  // A valid code always refers to a line that is still pending.
  a_code_pending: assert property (@(posedge clk) disable iff (!rst_n)
    code_valid |-> pending[code]);

  // code_valid is only ever high in OUT.
  a_valid_in_out: assert property (@(posedge clk) disable iff (!rst_n)
    code_valid |-> (state == OUT));
`endif

endmodule

// File: tb/tb_encoder_8input_seq.sv
//-----------------------------------------------------------------------------
// tb_encoder_8input_seq
//
// Table-driven bench for encoder_8input_seq. Each table row gives a request
// vector, a stall length for the first code, the expected zero_err pulse and
// the expected number of codes. While a vector is offered, a small priority
// model pushes the expected {code, last} pairs into a scoreboard queue. A
// negedge monitor pops and compares an entry on every code handshake.
// Hand-written sequences cover reset mid-batch and fixed code orders.
//-----------------------------------------------------------------------------
module tb_encoder_8input_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_vec;
  logic       code_valid;
  logic       code_ready;
  logic [2:0] code;
  logic       last;
  logic       zero_err;

  always #5 clk = ~clk;

  encoder_8input_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_vec    (req_vec),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .code       (code),
    .last       (last),
    .zero_err   (zero_err)
  );

  typedef struct packed {
    logic [2:0] code;
    logic       last;
  } exp_t;

  typedef struct packed {
    logic [7:0] vec;
    logic [3:0] stall;   // cycles code_ready is held low on the first code
    logic       zero;    // expected zero_err pulse
    logic [3:0] n;       // expected number of codes
  } vec_t;

  exp_t       sb[$];
  int         hs_cyc[$];
  logic [2:0] hs_code[$];
  int         n_vec  = 0;
  int         n_miss = 0;
  int         cyc    = 0;
  logic [2:0] m_ls   = 3'd7;   // model copy of the round-robin pointer

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference priority: scan upward from the line after the pointer. In the
  // default build the pointer stays at 7, so the scan always starts at line 0.
  task automatic model_push(input logic [7:0] v);
    logic [7:0] p;
    logic [2:0] idx;
    p = v;
    while (p != 8'd0) begin
      idx = 3'd0;
      for (int k = 8; k >= 1; k--) begin
        if (p[3'(m_ls + 3'(k))]) idx = 3'(m_ls + 3'(k));
      end
      p[idx] = 1'b0;
      sb.push_back('{code: idx, last: (p == 8'd0)});
`ifdef ENCODER_RR_EN
      m_ls = idx;
`endif
    end
  endtask

  // A handshake completes on the next rising edge when both flags are high here.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && code_valid && code_ready) begin
      hs_cyc.push_back(cyc + 1);
      hs_code.push_back(code);
      check("code_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("code", 32'(code), 32'(e.code));
        check("last", 32'(last), 32'(e.last));
      end
    end
  end

  // Called at posedge+1. Returns with acc = cycle count of the accept edge.
  task automatic send(input logic [7:0] v, output int acc);
    req_valid = 1'b1;
    req_vec   = v;
    @(negedge clk);
    check("req_ready_idle", 32'(req_ready), 32'd1);
    model_push(v);
    @(posedge clk);
    #1;
    acc       = cyc;
    req_valid = 1'b0;
    req_vec   = 8'($urandom);
  endtask

  task automatic run_batch(input vec_t t, output int acc, output int rdy_cyc);
    int budget;
    hs_cyc.delete();
    hs_code.delete();
    code_ready = (t.stall == 4'd0);
    send(t.vec, acc);
    check("zero_err_pulse", 32'(zero_err), 32'(t.zero));
    if (t.stall != 4'd0) begin
      budget = 20;
      while (!code_valid && budget > 0) begin
        @(posedge clk);
        #1;
        budget--;
      end
      // Offer a vector while busy: it must be ignored.
      req_valid = 1'b1;
      req_vec   = 8'hFF;
      for (int s = 0; s < int'(t.stall); s++) begin
        check("stall_valid", 32'(code_valid), 32'd1);
        check("stall_req_ready", 32'(req_ready), 32'd0);
        if (sb.size() != 0) check("stall_code", 32'(code), 32'(sb[0].code));
        @(posedge clk);
        #1;
      end
      req_valid  = 1'b0;
      code_ready = 1'b1;
    end
    budget = 100;
    while (sb.size() != 0 && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    check("drain_in_budget", 32'(budget > 0), 32'd1);
    rdy_cyc = cyc;
    check("req_ready_after_batch", 32'(req_ready), 32'd1);
    if (t.stall == 4'd0 && hs_cyc.size() > 0) begin
      check("first_code_latency", 32'(hs_cyc[0] - acc), 32'd2);
      for (int i = 1; i < hs_cyc.size(); i++) begin
        check("code_spacing", 32'(hs_cyc[i] - hs_cyc[i-1]), 32'd2);
      end
    end
    @(posedge clk);
    #1;
    check("zero_err_cleared", 32'(zero_err), 32'd0);
    check("code_valid_idle", 32'(code_valid), 32'd0);
    check("code_count", 32'(hs_cyc.size()), 32'(t.n));
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    sb.delete();
    m_ls = 3'd7;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    vec_t tbl[9];
    int   acc;
    int   rdy;
    int   budget;

    tbl[0] = '{vec: 8'hA4, stall: 4'd0, zero: 1'b0, n: 4'd3};
    tbl[1] = '{vec: 8'h00, stall: 4'd0, zero: 1'b1, n: 4'd0};
    tbl[2] = '{vec: 8'h18, stall: 4'd5, zero: 1'b0, n: 4'd2};
    tbl[3] = '{vec: 8'h01, stall: 4'd0, zero: 1'b0, n: 4'd1};
    tbl[4] = '{vec: 8'h81, stall: 4'd0, zero: 1'b0, n: 4'd2};
    tbl[5] = '{vec: 8'hFF, stall: 4'd0, zero: 1'b0, n: 4'd8};
    tbl[6] = '{vec: 8'h55, stall: 4'd2, zero: 1'b0, n: 4'd4};
    tbl[7] = '{vec: 8'h80, stall: 4'd0, zero: 1'b0, n: 4'd1};
    tbl[8] = '{vec: 8'h3C, stall: 4'd0, zero: 1'b0, n: 4'd4};

    rst_n      = 1'b0;
    req_valid  = 1'b1;   // offered during reset: must not be captured
    req_vec    = 8'h40;
    code_ready = 1'b0;
    #1;
    check("reset_code_valid", 32'(code_valid), 32'd0);
    check("reset_outputs", {28'd0, code, last}, 32'd0);
    check("reset_zero_err", 32'(zero_err), 32'd0);
    check("reset_req_ready", 32'(req_ready), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n     = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++) begin
      run_batch(tbl[i], acc, rdy);
      if (i == 0 && hs_code.size() == 3) begin
        check("a4_order_0", 32'(hs_code[0]), 32'd2);
        check("a4_order_1", 32'(hs_code[1]), 32'd5);
        check("a4_order_2", 32'(hs_code[2]), 32'd7);
      end
      if (tbl[i].vec == 8'h81 && hs_code.size() == 2) begin
`ifdef ENCODER_RR_EN
        check("rr_81_first", 32'(hs_code[0]), 32'd7);
        check("rr_81_second", 32'(hs_code[1]), 32'd0);
`else
        check("fixed_81_first", 32'(hs_code[0]), 32'd0);
        check("fixed_81_second", 32'(hs_code[1]), 32'd7);
`endif
      end
      if (tbl[i].vec == 8'hFF) begin
        check("ff_ready_after_16", 32'(rdy - acc), 32'd16);
      end
    end

    // Reset in the middle of an 8'hFF batch while code 2 is presented.
    pulse_reset();
    hs_cyc.delete();
    hs_code.delete();
    code_ready = 1'b1;
    send(8'hFF, acc);
    budget = 20;
    while (sb.size() > 6 && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    code_ready = 1'b0;
    @(posedge clk);
    #1;
    check("prereset_valid", 32'(code_valid), 32'd1);
    check("prereset_code", 32'(code), 32'd2);
    rst_n = 1'b0;
    #1;
    check("midreset_code_valid", 32'(code_valid), 32'd0);
    check("midreset_outputs", {28'd0, code, last}, 32'd0);
    check("midreset_zero_err", 32'(zero_err), 32'd0);
    check("midreset_req_ready", 32'(req_ready), 32'd1);
    sb.delete();
    m_ls = 3'd7;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_batch('{vec: 8'h01, stall: 4'd0, zero: 1'b0, n: 4'd1}, acc, rdy);
    if (hs_code.size() == 1) check("post_reset_code", 32'(hs_code[0]), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
